// File: rtl/imem_fetch_unit_pkg.sv
// imem_fetch_pkg
// Shared constants and types for the instruction-fetch front end.
//   IMEM_ADDR_WIDTH : word-address width of the instruction SRAM port
//   XLEN            : architectural word / PC width
//   RESET_PC        : byte PC the fetch unit starts from after reset
//   fetch_entry_t   : one prefetch FIFO slot, the fetched word tagged with its PC
//   pc_in_range()   : word-aligned and inside the 4*2^addr_width byte window
package imem_fetch_pkg;

   localparam int IMEM_ADDR_WIDTH = 9;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // The compare is done one bit wider than the PC so the byte limit
   // itself never wraps, whatever the address width.
   function automatic logic pc_in_range(input logic [XLEN-1:0] pc,
                                        input int unsigned addr_width);
      logic [XLEN:0] limit;
      limit = (XLEN+1)'(4) << addr_width;
      return (pc[1:0] == 2'b00) && ({1'b0, pc} < limit);
   endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// imem_fetch_unit_if
// Bundles the SRAM read port 1 and the decode-side instruction stream.
//   mem_csb_o / mem_addr_o : active-low chip select and word address to the SRAM
//   mem_rdata_i            : SRAM dout1
//   instr_valid_o / instr_o / instr_pc_o : head of the prefetch FIFO
//   instr_ready_i          : decode accepts the head entry
// master = fetch unit side, slave = SRAM/decode side.
interface imem_fetch_unit_if
   import imem_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = XLEN
);

   logic                  mem_csb_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  instr_valid_o;
   logic [DATA_WIDTH-1:0] instr_o;
   logic [XLEN-1:0]       instr_pc_o;
   logic                  instr_ready_i;

   modport master (
      output mem_csb_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      input  mem_rdata_i, instr_ready_i
   );

   modport slave (
      input  mem_csb_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      output mem_rdata_i, instr_ready_i
   );

endinterface

// File: rtl/imem_fetch_unit_fifo.sv
// fetch_fifo
// Small circular prefetch buffer holding fetched words with their PCs.
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write push_data at the tail (ignored when full with no pop)
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard everything, overrides push and pop
//   head_data  : current head entry
//   count      : number of valid entries
//   full/empty : occupancy flags
module fetch_fifo
   import imem_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   fetch_entry_t     slots [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap explicitly so depths that are not a power of two work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full buffer is still accepted when the head leaves in
   // the same cycle, so back-to-back streaming never stalls.
   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = slots[rd_ptr];

   // Pointer and occupancy bookkeeping; flush simply rewinds everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset; only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (do_push & ~flush) begin
         slots[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit
// Instruction-fetch front end for read port 1 of the instruction SRAM.
// Keeps the fetch PC, issues one word read per cycle while FIFO credit is
// available, and hands fetched words to decode as a valid/ready stream
// tagged with their byte PC.
//   wb_clk_i, wb_rst_i : clock shared with SRAM clk1, async active-high reset
//   fetch_en_i         : allows new SRAM reads
//   redirect_valid_i   : load redirect_pc_i as the new PC, flush the queue
//   redirect_pc_i      : redirect target byte address
//   fetch_err_o        : sticky fault, PC out of range or misaligned
//   bus (master)       : SRAM port and instruction stream, see imem_fetch_unit_if
module imem_fetch_unit
   import imem_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = XLEN,
   parameter logic [XLEN-1:0] RESET_PC = imem_fetch_pkg::RESET_PC,
   // Must be at least 2 to sustain one instruction per cycle.
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 fetch_en_i,
   input  logic                 redirect_valid_i,
   input  logic [XLEN-1:0]      redirect_pc_i,
   output logic                 fetch_err_o,
   imem_fetch_unit_if.master    bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  inflight_pc;
   logic             inflight;
   logic             kill;
   logic             fetch_err;
   logic             pc_ok;
   logic             pop;
   logic             push;
   logic             issue;
   logic [CNT_W:0]   credit_used;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;

   assign pc_ok = pc_in_range(pc, ADDR_WIDTH);
   assign pop   = ~fifo_empty & bus.instr_ready_i;

   // Issue decision. Credit counts queued words plus the read already in
   // flight, minus the word leaving this cycle, so a slot is reserved for
   // every read before it is launched and the FIFO can never overflow.
   // Reset also gates the chip select so the SRAM stays idle while held.
   always_comb begin
      credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
      credit_used = credit_used - {{CNT_W{1'b0}}, pop};
      issue = ~wb_rst_i & fetch_en_i & ~redirect_valid_i & ~fetch_err & pc_ok &
              (credit_used < (CNT_W+1)'(FIFO_DEPTH));
   end

   // PC, in-flight tracking and the sticky fault. A redirect wins over
   // everything: it reloads the PC, clears the fault and marks any read
   // still in flight as killed so its late data is thrown away.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         kill        <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         inflight <= issue;
         kill     <= redirect_valid_i & inflight;
         if (redirect_valid_i) begin
            pc        <= redirect_pc_i;
            fetch_err <= 1'b0;
         end else begin
            if (issue) begin
               pc          <= pc + 32'd4;
               inflight_pc <= pc;
            end
            if (fetch_en_i & ~pc_ok) begin
               fetch_err <= 1'b1;
            end
         end
      end
   end

   // Read data lands one edge after issue. A word returning on the redirect
   // edge itself is dropped here, since the flush takes priority.
   assign push             = inflight & ~kill & ~redirect_valid_i;
   assign push_entry.pc    = inflight_pc;
   assign push_entry.instr = XLEN'(bus.mem_rdata_i);

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid_i),
      .head_data (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.mem_csb_o     = ~issue;
   assign bus.mem_addr_o    = pc[ADDR_WIDTH+1:2];
   assign bus.instr_valid_o = ~fifo_empty;
   assign bus.instr_o       = DATA_WIDTH'(head_entry.instr);
   assign bus.instr_pc_o    = head_entry.pc;
   assign fetch_err_o       = fetch_err;

   // The credit check should make a push into a full, non-draining FIFO
   // impossible.
   no_overflow_a: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
      !(fifo_full && push && !pop));

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit
// Drives imem_fetch_unit with directed and random fetch/redirect/ready
// traffic against a behavioural SRAM. Expected instructions are the word
// run starting at each redirect/reset target; a monitor pops and compares.
module tb_imem_fetch_unit;
   import imem_fetch_pkg::*;

   localparam int AW = 9;
   localparam int DEPTH = 2;
   localparam int NWORDS = 1 << AW;
   localparam logic [31:0] BOOT_PC = 32'h0000_0000;
   localparam longint BYTE_LIMIT = 4 * NWORDS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;
   int issues_seen = 0;

   imem_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

   imem_fetch_unit #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (32),
      .RESET_PC   (BOOT_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .wb_clk_i         (clk),
      .wb_rst_i         (rst),
      .fetch_en_i       (fetch_en),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .fetch_err_o      (fetch_err),
      .bus              (bus)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: captures the address on the posedge, drives dout on
   // the following negedge, holds dout otherwise.
   logic [31:0]   sram [NWORDS];
   logic [AW-1:0] sram_addr_q = '0;
   logic          sram_cap_q = 1'b0;

   always @(posedge clk) begin
      sram_cap_q <= (bus.mem_csb_o === 1'b0);
      if (bus.mem_csb_o === 1'b0) sram_addr_q <= bus.mem_addr_o;
   end

   always @(negedge clk) begin
      if (sram_cap_q) bus.mem_rdata_i <= sram[sram_addr_q];
   end

   // Reference model: after a redirect/reset to a target, the stream must be
   // the consecutive words from the target up to the end of memory, and
   // reads must walk the same addresses. Anything else is a fault.
   fetch_entry_t exp_q[$];
   longint       next_issue = 0;
   logic         model_err = 1'b0;

   function automatic logic addr_ok(input longint a);
      return (a % 4 == 0) && (a >= 0) && (a < BYTE_LIMIT);
   endfunction

   task automatic buildRun(input logic [31:0] start);
      fetch_entry_t e;
      exp_q.delete();
      next_issue = longint'(start);
      if (addr_ok(next_issue)) begin
         for (longint a = next_issue; a < BYTE_LIMIT; a += 4) begin
            e.pc = 32'(a);
            e.instr = sram[a / 4];
            exp_q.push_back(e);
         end
      end
   endtask

   // A redirect seen on an edge replaces the expected stream.
   always @(posedge clk) begin
      if (rst === 1'b0 && redirect_valid === 1'b1) buildRun(redirect_pc);
   end

   // Monitor: sampled mid-cycle, compares the fault flag, every SRAM read
   // and every accepted instruction against the model.
   always @(negedge clk) begin
      logic ok_now;
      fetch_entry_t exp_e;
      if (rst === 1'b0) begin
         checks++;
         if (fetch_err !== model_err) begin
            errors++;
            $display("[TB] FAIL fetch_err: got %0b expected %0b at %0t", fetch_err, model_err, $time);
         end
         ok_now = addr_ok(next_issue);
         if (bus.mem_csb_o === 1'b0) begin
            checks++;
            issues_seen++;
            if (!ok_now || bus.mem_addr_o !== AW'(next_issue / 4)) begin
               errors++;
               $display("[TB] FAIL issue_addr: got %0h expected %0h (legal=%0b) at %0t",
                        bus.mem_addr_o, next_issue / 4, ok_now, $time);
            end
            next_issue += 4;
         end
         if (redirect_valid === 1'b1) model_err = 1'b0;
         else if (fetch_en === 1'b1 && !ok_now) model_err = 1'b1;
         if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_instr: got pc %0h instr %0h expected none at %0t",
                        bus.instr_pc_o, bus.instr_o, $time);
            end else begin
               exp_e = exp_q.pop_front();
               if (bus.instr_pc_o !== exp_e.pc || bus.instr_o !== exp_e.instr) begin
                  errors++;
                  $display("[TB] FAIL instr_stream: got pc %0h instr %0h expected pc %0h instr %0h at %0t",
                           bus.instr_pc_o, bus.instr_o, exp_e.pc, exp_e.instr, $time);
               end
            end
         end
      end else begin
         model_err = 1'b0;
      end
   end

   task automatic applyStimulus(input logic en, input logic rdy, input logic redir,
                                input logic [31:0] target);
      @(posedge clk);
      #1;
      fetch_en = en;
      bus.instr_ready_i = rdy;
      redirect_valid = redir;
      redirect_pc = target;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      fetch_en = 1'b0;
      redirect_valid = 1'b0;
      bus.instr_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      buildRun(BOOT_PC);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base;
      int waited;
      int sel;
      logic redir;
      logic [31:0] tgt;

      for (int i = 0; i < NWORDS; i++) sram[i] = $urandom;
      sram[0] = 32'h13;
      sram[1] = 32'h93;
      sram[2] = 32'h113;
      sram[3] = 32'h193;
      bus.instr_ready_i = 1'b0;
      fetch_en = 1'b1;

      // Reset state, with fetch enabled to show reset alone holds the SRAM idle.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", bus.instr_valid_o, 0);
      checkOutput("reset_csb", bus.mem_csb_o, 1);
      checkOutput("reset_err", fetch_err, 0);

      // Test 1: stream from RESET_PC, one read and one instruction per cycle.
      buildRun(BOOT_PC);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.instr_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 4) begin
            checkOutput($sformatf("t1_csb%0d", k), bus.mem_csb_o, 0);
            checkOutput($sformatf("t1_addr%0d", k), bus.mem_addr_o, k);
         end
         if (k < 2) begin
            checkOutput($sformatf("t1_latency%0d", k), bus.instr_valid_o, 0);
         end else begin
            checkOutput($sformatf("t1_valid%0d", k), bus.instr_valid_o, 1);
            checkOutput($sformatf("t1_pc%0d", k), bus.instr_pc_o, 4 * (k - 2));
            checkOutput($sformatf("t1_instr%0d", k), bus.instr_o, 32'h13 + 32'h80 * (k - 2));
         end
      end

      // Test 2: decode stalled, exactly DEPTH reads are launched.
      applyReset();
      fetch_en = 1'b1;
      base = issues_seen;
      repeat (8) @(negedge clk);
      checkOutput("t2_issue_count", issues_seen - base, DEPTH);
      checkOutput("t2_csb_idle", bus.mem_csb_o, 1);
      checkOutput("t2_valid", bus.instr_valid_o, 1);
      checkOutput("t2_head_pc", bus.instr_pc_o, 0);
      checkOutput("t2_head_instr", bus.instr_o, 32'h13);
      repeat (7) applyStimulus(1, 1, 0, 0);

      // Test 3: redirect with one queued word and one read in flight.
      applyStimulus(1, 1, 1, 32'h40);
      applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("t3_flush1", bus.instr_valid_o, 0);
      applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("t3_flush2", bus.instr_valid_o, 0);
      applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("t3_valid", bus.instr_valid_o, 1);
      checkOutput("t3_pc", bus.instr_pc_o, 32'h40);
      checkOutput("t3_instr", bus.instr_o, sram[16]);

      // Test 4: last word is delivered, then the range fault latches.
      applyStimulus(1, 1, 1, 32'h7FC);
      repeat (6) applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("t4_err", fetch_err, 1);
      checkOutput("t4_csb", bus.mem_csb_o, 1);
      checkOutput("t4_valid", bus.instr_valid_o, 0);
      checkOutput("t4_last_drained", exp_q.size(), 0);
      applyStimulus(1, 1, 1, 32'h0);
      applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("t4_err_clear", fetch_err, 0);
      repeat (2) applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("t4_resume", bus.instr_valid_o, 1);

      // Test 5: misaligned target faults without touching the SRAM.
      applyStimulus(1, 1, 1, 32'h42);
      base = issues_seen;
      repeat (5) applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("t5_err", fetch_err, 1);
      checkOutput("t5_no_access", issues_seen - base, 0);

      // Test 6: asynchronous reset with a full FIFO.
      applyStimulus(1, 1, 1, 32'h100);
      repeat (6) applyStimulus(1, 0, 0, 0);
      @(negedge clk);
      checkOutput("t6_full_valid", bus.instr_valid_o, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_async_valid", bus.instr_valid_o, 0);
      checkOutput("t6_async_csb", bus.mem_csb_o, 1);
      repeat (2) @(posedge clk);
      #1;
      buildRun(BOOT_PC);
      rst = 1'b0;
      bus.instr_ready_i = 1'b1;
      waited = 0;
      @(negedge clk);
      while (bus.instr_valid_o !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("t6_valid_in_bound", bus.instr_valid_o, 1);
      checkOutput("t6_first_pc", bus.instr_pc_o, BOOT_PC);

      // Random traffic: stalls, fetch gaps and redirects of every kind.
      for (int c = 0; c < 600; c++) begin
         redir = ($urandom_range(0, 15) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 6) tgt = 32'($urandom_range(0, NWORDS - 1)) << 2;
         else if (sel < 8) tgt = 32'h7F0 + (32'($urandom_range(0, 3)) << 2);
         else if (sel == 8) tgt = (32'($urandom_range(0, NWORDS - 1)) << 2) | 32'($urandom_range(1, 3));
         else tgt = 32'h800 + (32'($urandom_range(0, 255)) << 2);
         applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, redir, tgt);
      end

      applyStimulus(1, 1, 1, 32'h0);
      repeat (10) applyStimulus(1, 1, 0, 0);
      @(negedge clk);
      checkOutput("final_stream", bus.instr_valid_o, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
